// File: rtl/multicycle_core_ctrl.sv
// multicycle_core_ctrl: PC, register file and fetch/decode/execute/write sequencer for a multicycle RISC-V core.
// Define CORE_PERF_CNT_EN to build the 64-bit cycle/instret counters; otherwise both outputs read 0.
module multicycle_core_ctrl #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(500)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            HALT,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_ACK,
  input  logic [31:0]     IMEM_DATA,
  output logic [31:0]     INSTRUCTION,
  input  logic [4:0]      RS1_IDX,
  input  logic [4:0]      RS2_IDX,
  output logic [XLEN-1:0] RS1_VAL,
  output logic [XLEN-1:0] RS2_VAL,
  output logic            EXEC_START,
  input  logic            EXEC_DONE,
  input  logic [XLEN-1:0] JUMP_DEST,
  input  logic            WB_EN,
  input  logic [4:0]      WB_RD,
  input  logic [XLEN-1:0] WB_DATA,
  output logic            RETIRE,
  output logic [2:0]      STATE,
  input  logic [4:0]      DBG_IDX,
  output logic [XLEN-1:0] DBG_DATA,
  output logic [63:0]     PERF_CYCLES,
  output logic [63:0]     PERF_INSTRET
);
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3, WRITE = 3'd4} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, rs1_rd, rs2_rd;
  logic [31:0] instr_q, instr_d;
  logic first_q, first_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  function automatic logic in_range(input logic [4:0] i);
    return i != 5'd0 && int'(i) < NREGS;
  endfunction
  assign rs1_rd = in_range(RS1_IDX) ? regs_q[RS1_IDX[IW-1:0]] : '0;
  assign rs2_rd = in_range(RS2_IDX) ? regs_q[RS2_IDX[IW-1:0]] : '0;
  assign DBG_DATA = in_range(DBG_IDX) ? regs_q[DBG_IDX[IW-1:0]] : '0;
  assign IMEM_ADDR = pc_q;
  assign INSTRUCTION = instr_q;
  assign RS1_VAL = rs1_q;
  assign RS2_VAL = rs2_q;
  assign STATE = state_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    regs_d = regs_q;
    first_d = 1'b0;
    IMEM_REQ = 1'b0;
    EXEC_START = 1'b0;
    RETIRE = 1'b0;
    case (state_q)
      IDLE: state_d = HALT ? IDLE : FETCH;
      FETCH: begin
        IMEM_REQ = 1'b1;
        instr_d = IMEM_ACK ? IMEM_DATA : instr_q;
        state_d = IMEM_ACK ? DECODE : FETCH;
      end
      DECODE: begin
        rs1_d = rs1_rd;
        rs2_d = rs2_rd;
        first_d = 1'b1;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        EXEC_START = first_q;
        pc_d = EXEC_DONE ? JUMP_DEST : pc_q;
        state_d = EXEC_DONE ? WRITE : EXECUTE;
      end
      WRITE: begin
        RETIRE = 1'b1;
        if (WB_EN && in_range(WB_RD)) regs_d[WB_RD[IW-1:0]] = WB_DATA;
        state_d = HALT ? IDLE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      instr_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      first_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == 2) ? SP_INIT : '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      first_q <= first_d;
      regs_q <= regs_d;
    end
  end
`ifdef CORE_PERF_CNT_EN
  logic [63:0] cyc_q, cyc_d, ret_q, ret_d;
  always_comb begin
    cyc_d = cyc_q + 64'd1;
    ret_d = ret_q + {63'd0, RETIRE};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end
  assign PERF_CYCLES = cyc_q;
  assign PERF_INSTRET = ret_q;
`else
  assign PERF_CYCLES = '0;
  assign PERF_INSTRET = '0;
`endif
endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// tb_multicycle_core_ctrl: directed + random stimulus against a cycle-level reference model of the core sequencer.
module tb_multicycle_core_ctrl;
  logic clk = 1'b0, rst = 1'b1, halt = 1'b0, ack = 1'b0, done = 1'b0, wb_en = 1'b0;
  logic [31:0] idata = '0, jd = '0, wb_data = '0;
  logic [4:0] rs1i = '0, rs2i = '0, wb_rd = '0, dbg = '0;
  logic req, start, retire, req16, start16, retire16;
  logic [2:0] state, state16;
  logic [31:0] addr, instr, rs1v, rs2v, dbgd, addr16, instr16, rs1v16, rs2v16, dbgd16;
  logic [63:0] pcyc, pret, pcyc16, pret16;
  int checks = 0, fails = 0, nstart = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  multicycle_core_ctrl u32 (
    .CLK(clk), .RST(rst), .HALT(halt), .IMEM_REQ(req), .IMEM_ADDR(addr), .IMEM_ACK(ack),
    .IMEM_DATA(idata), .INSTRUCTION(instr), .RS1_IDX(rs1i), .RS2_IDX(rs2i), .RS1_VAL(rs1v),
    .RS2_VAL(rs2v), .EXEC_START(start), .EXEC_DONE(done), .JUMP_DEST(jd), .WB_EN(wb_en),
    .WB_RD(wb_rd), .WB_DATA(wb_data), .RETIRE(retire), .STATE(state), .DBG_IDX(dbg),
    .DBG_DATA(dbgd), .PERF_CYCLES(pcyc), .PERF_INSTRET(pret));

  multicycle_core_ctrl #(.NREGS(16)) u16 (
    .CLK(clk), .RST(rst), .HALT(halt), .IMEM_REQ(req16), .IMEM_ADDR(addr16), .IMEM_ACK(ack),
    .IMEM_DATA(idata), .INSTRUCTION(instr16), .RS1_IDX(rs1i), .RS2_IDX(rs2i), .RS1_VAL(rs1v16),
    .RS2_VAL(rs2v16), .EXEC_START(start16), .EXEC_DONE(done), .JUMP_DEST(jd), .WB_EN(wb_en),
    .WB_RD(wb_rd), .WB_DATA(wb_data), .RETIRE(retire16), .STATE(state16), .DBG_IDX(dbg),
    .DBG_DATA(dbgd16), .PERF_CYCLES(pcyc16), .PERF_INSTRET(pret16));

  // reference model: phase number follows the documented STATE values
  int m_st = 0;
  bit m_first = 1'b0;
  logic [31:0] m_pc = '0, m_instr = '0, m_a32 = '0, m_b32 = '0, m_a16 = '0, m_b16 = '0;
  logic [31:0] r32 [32];
  logic [31:0] r16 [16];
  logic [63:0] m_cyc = '0, m_ret = '0;

  function automatic logic [31:0] rd32(input logic [4:0] i);
    return (i == 5'd0) ? 32'd0 : r32[i];
  endfunction
  function automatic logic [31:0] rd16(input logic [4:0] i);
    return (i == 5'd0 || i >= 5'd16) ? 32'd0 : r16[i[3:0]];
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic mdl_step();
    if (rst) begin
      m_st = 0; m_pc = '0; m_instr = '0; m_first = 1'b0; m_cyc = '0; m_ret = '0;
      m_a32 = '0; m_b32 = '0; m_a16 = '0; m_b16 = '0;
      foreach (r32[i]) r32[i] = (i == 2) ? 32'd500 : 32'd0;
      foreach (r16[i]) r16[i] = (i == 2) ? 32'd500 : 32'd0;
    end else begin
      m_cyc++;
      if (m_st == 4) m_ret++;
      if (m_st == 0) begin
        if (!halt) m_st = 1;
      end else if (m_st == 1) begin
        if (ack) begin m_instr = idata; m_st = 2; end
      end else if (m_st == 2) begin
        m_a32 = rd32(rs1i); m_b32 = rd32(rs2i); m_a16 = rd16(rs1i); m_b16 = rd16(rs2i);
        m_first = 1'b1; m_st = 3;
      end else if (m_st == 3) begin
        m_first = 1'b0;
        if (done) begin m_pc = jd; m_st = 4; end
      end else begin
        if (wb_en && wb_rd != 5'd0) begin
          r32[wb_rd] = wb_data;
          if (wb_rd < 5'd16) r16[wb_rd[3:0]] = wb_data;
        end
        m_st = halt ? 0 : 1;
      end
    end
  endtask

  task automatic look();
    #1;
    if (chk_en) begin
      chk("state", 64'(state), 64'(m_st));
      chk("state16", 64'(state16), 64'(m_st));
      chk("imem_req", 64'(req), 64'(m_st == 1));
      chk("imem_addr", 64'(addr), 64'(m_pc));
      chk("instruction", 64'(instr), 64'(m_instr));
      chk("rs1_val", 64'(rs1v), 64'(m_a32));
      chk("rs2_val", 64'(rs2v), 64'(m_b32));
      chk("rs1_val16", 64'(rs1v16), 64'(m_a16));
      chk("rs2_val16", 64'(rs2v16), 64'(m_b16));
      chk("exec_start", 64'(start), 64'(m_st == 3 && m_first));
      chk("retire", 64'(retire), 64'(m_st == 4));
      chk("dbg_data", 64'(dbgd), 64'(rd32(dbg)));
      chk("dbg_data16", 64'(dbgd16), 64'(rd16(dbg)));
`ifdef CORE_PERF_CNT_EN
      chk("perf_cycles", pcyc, m_cyc);
      chk("perf_instret", pret, m_ret);
`else
      chk("perf_cycles", pcyc, 64'd0);
      chk("perf_instret", pret, 64'd0);
`endif
    end
  endtask

  task automatic adv();
    mdl_step();
    @(negedge clk);
  endtask

  task automatic step();
    look();
    adv();
  endtask

  task automatic run_instr(input logic [4:0] rd, input logic [31:0] d, input logic [4:0] s1);
    ack = 1'b1; done = 1'b1; wb_en = 1'b1; wb_rd = rd; wb_data = d; rs1i = s1;
    repeat (4) begin jd = m_pc + 32'd4; step(); end
  endtask

  initial begin
    @(negedge clk);
    step();
    chk_en = 1'b1;
    dbg = 5'd2;
    look();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_x2", 64'(dbgd), 64'd500);
    chk("rst_req", 64'(req), 64'd0);
    adv();
    // zero-wait addi x14,x0,5 stream
    rst = 1'b0; ack = 1'b1; done = 1'b1; idata = 32'h00500713; wb_en = 1'b1; wb_rd = 5'd14; wb_data = 32'd5;
    for (int k = 1; k <= 13; k++) begin
      jd = m_pc + 32'd4; dbg = 5'd14;
      look();
      if (k == 1) chk("idle_c1", 64'(state), 64'd0);
      if (k == 4) chk("retire_c4", 64'(retire), 64'd0);
      if (k == 5) chk("retire_c5", 64'(retire), 64'd1);
      if (k == 5) chk("x14_before", 64'(dbgd), 64'd0);
      if (k == 6) chk("x14_after", 64'(dbgd), 64'd5);
      if (k == 2 || k == 6 || k == 10) chk("addr_step", 64'(addr), 64'(k - 2));
      adv();
    end
    // wait states: ACK after 3 cycles, DONE after 2
    for (int j = 0; j <= 8; j++) begin
      ack = (j >= 3); done = (j >= 7); jd = m_pc + 32'd4;
      look();
`ifdef CORE_PERF_CNT_EN
      if (j == 0) begin chk("perf_cyc13", pcyc, 64'd13); chk("perf_ret3", pret, 64'd3); end
`else
      if (j == 0) begin chk("perf_cyc_off", pcyc, 64'd0); chk("perf_ret_off", pret, 64'd0); end
`endif
      if (j <= 3) begin chk("wait_req", 64'(req), 64'd1); chk("wait_addr", 64'(addr), 64'd12); end
      if (j == 7) chk("wait_no_retire", 64'(retire), 64'd0);
      if (j == 8) chk("wait_retire9", 64'(retire), 64'd1);
      nstart += int'(start);
      adv();
    end
    chk("start_pulses", 64'(nstart), 64'd1);
    // x0 and NREGS range
    run_instr(5'd0, 32'hDEAD, 5'd0);
    run_instr(5'd20, 32'h1234, 5'd0);
    run_instr(5'd5, 32'd7, 5'd20);
    dbg = 5'd0;
    look();
    chk("x0_zero", 64'(dbgd), 64'd0);
    chk("x0_zero16", 64'(dbgd16), 64'd0);
    chk("rs1_x20", 64'(rs1v), 64'h1234);
    chk("rs1_x20_n16", 64'(rs1v16), 64'd0);
    dbg = 5'd20;
    #1;
    chk("dbg_x20", 64'(dbgd), 64'h1234);
    chk("dbg_x20_n16", 64'(dbgd16), 64'd0);
    adv();
    // reset while EXECUTE waits on DONE
    done = 1'b0; ack = 1'b1;
    for (int i = 0; i < 8 && m_st != 3; i++) step();
    step();
    done = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; ack = 1'b0;
    look();
    chk("rstx_state", 64'(state), 64'd0);
    chk("rstx_pc", 64'(addr), 64'd0);
    adv();
    for (int i = 0; i < 4; i++) begin
      look();
      chk("rstx_no_retire", 64'(retire), 64'd0);
      chk("rstx_addr", 64'(addr), 64'd0);
      adv();
    end
    // HALT raised during EXECUTE
    ack = 1'b1; done = 1'b0;
    step();
    step();
    halt = 1'b1;
    step();
    done = 1'b1; jd = 32'h100;
    step();
    look();
    chk("halt_retire", 64'(retire), 64'd1);
    adv();
    for (int i = 0; i < 2; i++) begin
      look();
      chk("halt_idle", 64'(state), 64'd0);
      chk("halt_req", 64'(req), 64'd0);
      adv();
    end
    halt = 1'b0;
    step();
    look();
    chk("resume_fetch", 64'(state), 64'd1);
    chk("resume_addr", 64'(addr), 64'h100);
    adv();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      halt = ($urandom_range(0, 7) == 0);
      ack = 1'($urandom_range(0, 1));
      done = 1'($urandom_range(0, 1));
      idata = $urandom; jd = $urandom; wb_data = $urandom;
      rs1i = 5'($urandom); rs2i = 5'($urandom); wb_rd = 5'($urandom); dbg = 5'($urandom);
      wb_en = 1'($urandom_range(0, 1));
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
